// File: rtl/matmul_engine.sv
// matmul_engine
//   Square NxN matrix multiplier C = A * B with one multiply-accumulate per
//   clock. Operands are written element by element while idle; once every
//   element of A and B has been written the engine computes all of C in N^3
//   cycles. C is then read out in DW-bit slices. After N*N*NB reads the
//   engine returns to idle and waits for a fresh set of operand loads.
//
//   Build option: define MATMUL_ENGINE_SIGNED_EN to treat operands and C as
//   two's-complement (products sign-extended). Without it all arithmetic is
//   unsigned.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active high
//   load_en       write in_data into the operand store this cycle
//   load_sel_ab   0 = matrix A, 1 = matrix B
//   load_index    row-major element index (row*N+col)
//   in_data       operand element
//   output_en     read strobe, counted while in OUTPUT
//   output_sel    row-major index of the C element to read
//   output_slice  DW-bit slice of that element, 0 = least significant
//   out_data      selected slice, 0 when not reading in OUTPUT
//   busy          high while computing
//   done          one-cycle pulse on the first OUTPUT cycle
//
// States
//   IDLE    | accept operand loads, wait until all elements are loaded
//   COMPUTE | one MAC per cycle, k innermost, then j, then i
//   OUTPUT  | serve slice reads until N*N*NB reads have been made
module matmul_engine #(
    parameter int N  = 2,
    parameter int DW = 8,
    localparam int IW = $clog2(N * N),
    localparam int CW = 2 * DW + $clog2(N),
    localparam int NB = (CW + DW - 1) / DW,
    localparam int SW = ($clog2(NB) > 1) ? $clog2(NB) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic          load_sel_ab,
    input  logic [IW-1:0] load_index,
    input  logic [DW-1:0] in_data,
    input  logic          output_en,
    input  logic [IW-1:0] output_sel,
    input  logic [SW-1:0] output_slice,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    localparam int NN  = N * N;
    localparam int PW  = 2 * DW;
    localparam int KW  = $clog2(N);
    localparam int NRD = NN * NB;
    localparam int RW  = $clog2(NRD + 1);
    localparam int XW  = NB * DW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   a_q [NN];
    logic [DW-1:0]   b_q [NN];
    logic [CW-1:0]   c_q [NN];
    logic [2*NN-1:0] ld_flags_q, ld_flags_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [KW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [RW-1:0]   rd_cnt_q, rd_cnt_d;
    logic            done_q, done_d;

    logic            load_ok;
    logic [IW-1:0]   a_idx, b_idx, c_idx;
    logic [DW-1:0]   a_el, b_el;
    logic [PW-1:0]   prod;
    logic [CW-1:0]   prod_ext;
    logic            c_we;
    logic [XW-1:0]   c_ext;

    assign load_ok = (state_q == S_IDLE) && load_en && (32'(load_index) < NN);

    // Operand storage is deliberately not reset; contents survive OUTPUT.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            if (load_sel_ab) begin
                b_q[load_index] <= in_data;
            end else begin
                a_q[load_index] <= in_data;
            end
        end
    end

    always_comb begin
        a_idx = IW'(int'(i_q) * N + int'(k_q));
        b_idx = IW'(int'(k_q) * N + int'(j_q));
        c_idx = IW'(int'(i_q) * N + int'(j_q));
        a_el  = a_q[a_idx];
        b_el  = b_q[b_idx];
`ifdef MATMUL_ENGINE_SIGNED_EN
        prod     = $signed({{DW{a_el[DW-1]}}, a_el}) * $signed({{DW{b_el[DW-1]}}, b_el});
        prod_ext = {{(CW - PW){prod[PW-1]}}, prod};
`else
        prod     = {{DW{1'b0}}, a_el} * {{DW{1'b0}}, b_el};
        prod_ext = {{(CW - PW){1'b0}}, prod};
`endif
    end

    always_comb begin
        state_d    = state_q;
        ld_flags_d = ld_flags_q;
        acc_d      = acc_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        rd_cnt_d   = rd_cnt_q;
        done_d     = 1'b0;
        c_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                for (int e = 0; e < NN; e++) begin
                    if (load_ok && (32'(load_index) == e)) begin
                        if (load_sel_ab) begin
                            ld_flags_d[NN + e] = 1'b1;
                        end else begin
                            ld_flags_d[e] = 1'b1;
                        end
                    end
                end
                // Decided on the registered flags, so COMPUTE starts on the
                // edge after the last flag is set.
                if (&ld_flags_q) begin
                    state_d = S_COMPUTE;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            S_COMPUTE: begin
                acc_d = (k_q == '0) ? prod_ext : acc_q + prod_ext;
                if (k_q == KW'(N - 1)) begin
                    c_we = 1'b1;
                    k_d  = '0;
                    if (j_q == KW'(N - 1)) begin
                        j_d = '0;
                        if (i_q == KW'(N - 1)) begin
                            i_d      = '0;
                            rd_cnt_d = '0;
                            done_d   = 1'b1;
                            state_d  = S_OUTPUT;
                        end else begin
                            i_d = i_q + KW'(1);
                        end
                    end else begin
                        j_d = j_q + KW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_OUTPUT: begin
                if (output_en) begin
                    if (32'(rd_cnt_q) + 1 == NRD) begin
                        rd_cnt_d   = '0;
                        ld_flags_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ld_flags_q <= '0;
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            rd_cnt_q   <= '0;
            done_q     <= 1'b0;
            for (int e = 0; e < NN; e++) begin
                c_q[e] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ld_flags_q <= ld_flags_d;
            acc_q      <= acc_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            rd_cnt_q   <= rd_cnt_d;
            done_q     <= done_d;
            if (c_we) begin
                c_q[c_idx] <= acc_d;
            end
        end
    end

    // Readout: C is zero-padded to NB*DW so the top slice reads 0 above CW.
    always_comb begin
        c_ext    = '0;
        out_data = '0;
        if ((state_q == S_OUTPUT) && output_en &&
            (32'(output_sel) < NN) && (32'(output_slice) < NB)) begin
            c_ext[CW-1:0] = c_q[output_sel];
            out_data      = c_ext[int'(output_slice) * DW +: DW];
        end
    end

    assign busy = (state_q == S_COMPUTE);
    assign done = done_q;

endmodule

// File: tb/tb_matmul_engine.sv
module tb_matmul_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       ld2, sab2, oe2, busy2, done2;
    logic [1:0] li2, os2, sl2;
    logic [7:0] d2, q2;

    logic       ld3, sab3, oe3, busy3, done3;
    logic [3:0] li3, os3;
    logic [1:0] sl3;
    logic [7:0] d3, q3;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp2_q[$];
    logic [7:0] exp3_q[$];
    logic [7:0] e2, e3;

    matmul_engine #(.N(2), .DW(8)) u2 (
        .clk(clk), .rst(rst), .load_en(ld2), .load_sel_ab(sab2),
        .load_index(li2), .in_data(d2), .output_en(oe2), .output_sel(os2),
        .output_slice(sl2), .out_data(q2), .busy(busy2), .done(done2)
    );

    matmul_engine #(.N(3), .DW(8)) u3 (
        .clk(clk), .rst(rst), .load_en(ld3), .load_sel_ab(sab3),
        .load_index(li3), .in_data(d3), .output_en(oe3), .output_sel(os3),
        .output_slice(sl3), .out_data(q3), .busy(busy3), .done(done3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard monitors: one pop per strobed read cycle.
    always @(negedge clk) begin
        if (oe2) begin
            if (exp2_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd2: unexpected read, got %0d expected none", q2);
            end else begin
                e2 = exp2_q.pop_front();
                check("rd2", q2, e2);
            end
        end
        if (oe3) begin
            if (exp3_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd3: unexpected read, got %0d expected none", q3);
            end else begin
                e3 = exp3_q.pop_front();
                check("rd3", q3, e3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadmat2(input logic sel, input logic [7:0] m[4]);
        for (int e = 0; e < 4; e++) begin
            ld2 = 1'b1; sab2 = sel; li2 = 2'(e); d2 = m[e];
            tick();
        end
        ld2 = 1'b0;
    endtask

    task automatic read2(input int sel, input int slice, input logic [7:0] exp);
        tick();
        exp2_q.push_back(exp);
        oe2 = 1'b1; os2 = 2'(sel); sl2 = 2'(slice);
    endtask

    task automatic read3(input int sel, input int slice, input logic [7:0] exp);
        tick();
        exp3_q.push_back(exp);
        oe3 = 1'b1; os3 = 4'(sel); sl3 = 2'(slice);
    endtask

    task automatic rd_end();
        tick();
        oe2 = 1'b0;
        oe3 = 1'b0;
    endtask

    // Waits for the compute phase of one engine; drives ignored loads into
    // u2 while it is busy. Leaves the bench at the negedge of OUTPUT cycle 2.
    task automatic run(input int which, input int exp_busy);
        int  nb   = 0;
        bit  seen = 0;
        bit  b;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            b = (which == 2) ? busy2 : busy3;
            if (b) begin
                nb++;
                seen = 1;
                if (which == 2) begin
                    ld2 = 1'b1; sab2 = 1'b0; li2 = 2'd0; d2 = 8'hAA;
                end
            end else if (seen) begin
                break;
            end
        end
        ld2 = 1'b0;
        check($sformatf("busy_cycles_u%0d", which), nb, exp_busy);
        check($sformatf("done_pulse_u%0d", which), (which == 2) ? done2 : done3, 1);
        @(negedge clk);
        check($sformatf("done_once_u%0d", which), (which == 2) ? done2 : done3, 0);
    endtask

    // 12 counted reads: one out-of-range slice, slices 2 and 1 of all,
    // slice 0 of elements 0..2. The 13th read finds the engine idle.
    task automatic readout2(input logic [16:0] c[4]);
        logic [16:0] v;
        read2(0, 3, 8'h00);
        for (int s = 2; s >= 1; s--) begin
            for (int e = 0; e < 4; e++) begin
                v = c[e];
                read2(e, s, 8'(v >> (8 * s)));
            end
        end
        for (int e = 0; e < 3; e++) begin
            v = c[e];
            read2(e, 0, v[7:0]);
        end
        read2(3, 0, 8'h00);
        rd_end();
    endtask

    logic [7:0]  ma[4], mb[4];
    logic [16:0] cx[4];
    bit          saw_done, saw_busy;
    int          nbz;

    initial begin
        rst = 1'b1;
        ld2 = 0; sab2 = 0; li2 = 0; d2 = 0; oe2 = 0; os2 = 0; sl2 = 0;
        ld3 = 0; sab3 = 0; li3 = 0; d3 = 0; oe3 = 0; os3 = 0; sl3 = 0;
        #22;
        check("rst_busy", busy2, 0);
        check("rst_done", done2, 0);
        check("rst_out",  q2,    0);
        @(negedge clk);
        rst = 1'b0;

        // Reads while idle return 0 and are not counted.
        read2(0, 0, 8'h00);
        read2(1, 1, 8'h00);
        rd_end();

        // Basic unsigned product.
        ma = '{8'd1, 8'd2, 8'd3, 8'd4};
        mb = '{8'd5, 8'd6, 8'd7, 8'd8};
        cx = '{17'd19, 17'd22, 17'd43, 17'd50};
        loadmat2(1'b0, ma);
        loadmat2(1'b1, mb);
        run(2, 8);
        readout2(cx);

        // Loaded flags were cleared: reloading only A must not start compute.
        loadmat2(1'b0, ma);
        saw_busy = 0;
        repeat (6) begin
            @(negedge clk);
            saw_busy |= busy2;
        end
        check("flags_cleared", saw_busy, 0);

        // All-ones operands.
        ma = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef MATMUL_ENGINE_SIGNED_EN
        cx = '{17'd2, 17'd2, 17'd2, 17'd2};
`else
        cx = '{17'h1FC02, 17'h1FC02, 17'h1FC02, 17'h1FC02};
`endif
        loadmat2(1'b0, ma);
        loadmat2(1'b1, ma);
        run(2, 8);
        readout2(cx);

        // 0x80 x 0x7F operands.
        ma = '{8'h80, 8'h80, 8'h80, 8'h80};
        mb = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
`ifdef MATMUL_ENGINE_SIGNED_EN
        cx = '{17'h18100, 17'h18100, 17'h18100, 17'h18100};
`else
        cx = '{17'h07F00, 17'h07F00, 17'h07F00, 17'h07F00};
`endif
        loadmat2(1'b0, ma);
        loadmat2(1'b1, mb);
        run(2, 8);
        readout2(cx);

        // Reset on COMPUTE cycle 3.
        ma = '{8'd1, 8'd2, 8'd3, 8'd4};
        mb = '{8'd5, 8'd6, 8'd7, 8'd8};
        loadmat2(1'b0, ma);
        loadmat2(1'b1, mb);
        nbz = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (busy2) nbz++;
            if (nbz == 3) break;
        end
        check("rst_point_reached", nbz, 3);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy2, 0);
        check("rst_mid_done", done2, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        saw_busy = 0;
        repeat (12) begin
            @(negedge clk);
            saw_done |= done2;
            saw_busy |= busy2;
        end
        check("rst_no_done", saw_done, 0);
        check("rst_no_busy", saw_busy, 0);
        cx = '{17'd19, 17'd22, 17'd43, 17'd50};
        loadmat2(1'b0, ma);
        loadmat2(1'b1, mb);
        run(2, 8);
        readout2(cx);

        // N=3: identity times 1..9, with out-of-range loads and reads.
        ld3 = 1'b1; sab3 = 1'b0; li3 = 4'd9;  d3 = 8'd77; tick();
        ld3 = 1'b1; sab3 = 1'b1; li3 = 4'd12; d3 = 8'd55; tick();
        for (int e = 0; e < 9; e++) begin
            ld3 = 1'b1; sab3 = 1'b0; li3 = 4'(e);
            d3 = (e == 0 || e == 4 || e == 8) ? 8'd1 : 8'd0;
            tick();
        end
        for (int e = 0; e < 9; e++) begin
            ld3 = 1'b1; sab3 = 1'b1; li3 = 4'(e); d3 = 8'(e + 1);
            tick();
        end
        ld3 = 1'b0;
        run(3, 27);
        for (int e = 0; e < 9; e++) read3(e, 2, 8'h00);
        for (int e = 0; e < 8; e++) read3(e, 1, 8'h00);
        read3(9, 0, 8'h00);
        for (int e = 0; e < 9; e++) read3(e, 0, 8'(e + 1));
        read3(0, 0, 8'h00);
        rd_end();

        repeat (3) @(negedge clk);
        check("sb_leftover", exp2_q.size() + exp3_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
